// File: rtl/status_flag_reg_if.sv
// Bus between the ALU flag generator / decode and the condition-code stage.
// The master drives flags and control; the slave returns status and the branch decision.
interface status_flag_reg_if;
    logic       zd_flag;
    logic       carry_flag;
    logic       overflow_flag;
    logic       negative_flag;
    logic       flag_we;
    logic       sr_we;
    logic [3:0] sr_wdata;
    logic       stall;
    logic       int_save;
    logic       int_restore;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic [3:0] sr_rdata;
    logic       shadow_valid;
    logic       take_valid;
    logic       take_branch;

    modport master (
        output zd_flag, carry_flag, overflow_flag, negative_flag,
        output flag_we, sr_we, sr_wdata, stall, int_save, int_restore,
        output cond_valid, cond_code,
        input  sr_rdata, shadow_valid, take_valid, take_branch
    );

    modport slave (
        input  zd_flag, carry_flag, overflow_flag, negative_flag,
        input  flag_we, sr_we, sr_wdata, stall, int_save, int_restore,
        input  cond_valid, cond_code,
        output sr_rdata, shadow_valid, take_valid, take_branch
    );
endinterface

// File: rtl/status_flag_reg.sv
// Architectural status register {N,Z,C,V} with one-level interrupt shadow
// and a registered branch-condition evaluator feeding the fetch/PC stage.
module status_flag_reg #(
    parameter bit         BYPASS   = 1'b1,
    parameter logic [3:0] SR_RESET = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    status_flag_reg_if.slave  bus
);

    logic [3:0] sr_q, sr_d;
    logic [3:0] shadow_q, shadow_d;
    logic       shadow_valid_q, shadow_valid_d;
    logic       take_valid_q, take_valid_d;
    logic       take_branch_q, take_branch_d;
    logic [3:0] flags_sel;
    logic       do_restore;

    function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] code);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (code)
            4'h0:    cond_eval = z;
            4'h1:    cond_eval = !z;
            4'h2:    cond_eval = c;
            4'h3:    cond_eval = !c;
            4'h4:    cond_eval = n;
            4'h5:    cond_eval = !n;
            4'h6:    cond_eval = v;
            4'h7:    cond_eval = !v;
            4'h8:    cond_eval = c & !z;
            4'h9:    cond_eval = !c | z;
            4'hA:    cond_eval = (n == v);
            4'hB:    cond_eval = (n != v);
            4'hC:    cond_eval = !z & (n == v);
            4'hD:    cond_eval = z | (n != v);
            4'hE:    cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    always_comb begin
        sr_d           = sr_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        take_valid_d   = 1'b0;
        take_branch_d  = take_branch_q;
        do_restore     = bus.int_restore & shadow_valid_q;

        if (!bus.stall) begin
            // A restore wins over everything, including a simultaneous save.
            if (do_restore) begin
                sr_d           = shadow_q;
                shadow_valid_d = 1'b0;
            end else begin
                if (bus.sr_we)
                    sr_d = bus.sr_wdata;
                else if (bus.flag_we)
                    sr_d = {bus.negative_flag, bus.zd_flag, bus.carry_flag, bus.overflow_flag};
                if (bus.int_save) begin
                    shadow_d       = sr_q;
                    shadow_valid_d = 1'b1;
                end
            end
        end

        flags_sel = BYPASS ? sr_d : sr_q;

        if (!bus.stall && bus.cond_valid) begin
            take_valid_d  = 1'b1;
            take_branch_d = cond_eval(flags_sel, bus.cond_code);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q           <= SR_RESET;
            shadow_q       <= 4'b0000;
            shadow_valid_q <= 1'b0;
            take_valid_q   <= 1'b0;
            take_branch_q  <= 1'b0;
        end else begin
            sr_q           <= sr_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            take_valid_q   <= take_valid_d;
            take_branch_q  <= take_branch_d;
        end
    end

    assign bus.sr_rdata     = sr_q;
    assign bus.shadow_valid = shadow_valid_q;
    assign bus.take_valid   = take_valid_q;
    assign bus.take_branch  = take_branch_q;

endmodule

// File: tb/tb_status_flag_reg.sv
// Directed bench for status_flag_reg: a BYPASS=1 and a BYPASS=0 instance share
// stimulus; expectations are queued per cycle and checked after each edge.
module tb_status_flag_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    status_flag_reg_if u_if1 ();
    status_flag_reg_if u_if0 ();

    status_flag_reg #(.BYPASS(1'b1), .SR_RESET(4'b0000)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));
    status_flag_reg #(.BYPASS(1'b0), .SR_RESET(4'b0000)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0));

    assign u_if0.zd_flag       = u_if1.zd_flag;
    assign u_if0.carry_flag    = u_if1.carry_flag;
    assign u_if0.overflow_flag = u_if1.overflow_flag;
    assign u_if0.negative_flag = u_if1.negative_flag;
    assign u_if0.flag_we       = u_if1.flag_we;
    assign u_if0.sr_we         = u_if1.sr_we;
    assign u_if0.sr_wdata      = u_if1.sr_wdata;
    assign u_if0.stall         = u_if1.stall;
    assign u_if0.int_save      = u_if1.int_save;
    assign u_if0.int_restore   = u_if1.int_restore;
    assign u_if0.cond_valid    = u_if1.cond_valid;
    assign u_if0.cond_code     = u_if1.cond_code;

    typedef struct {
        string      tag;
        logic [3:0] sr;
        logic       sv;
        logic       tv;
        logic       tb;
        logic       tb0;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference decode of the condition table, independent of the DUT.
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] code);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code)
            4'h0: return z;
            4'h1: return ~z;
            4'h2: return c;
            4'h3: return ~c;
            4'h4: return n;
            4'h5: return ~n;
            4'h6: return v;
            4'h7: return ~v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n ~^ v;
            4'hB: return n ^ v;
            4'hC: return !z && (n ~^ v);
            4'hD: return z || (n ^ v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] sr, input logic sv,
                        input logic tv, input logic tb, input logic tb0);
        exp_t e;
        e.tag = tag; e.sr = sr; e.sv = sv; e.tv = tv; e.tb = tb; e.tb0 = tb0;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        rst = 1'b0;
        u_if1.zd_flag = 1'b0; u_if1.carry_flag = 1'b0;
        u_if1.overflow_flag = 1'b0; u_if1.negative_flag = 1'b0;
        u_if1.flag_we = 1'b0; u_if1.sr_we = 1'b0; u_if1.sr_wdata = 4'h0;
        u_if1.stall = 1'b0; u_if1.int_save = 1'b0; u_if1.int_restore = 1'b0;
        u_if1.cond_valid = 1'b0; u_if1.cond_code = 4'h0;
    endtask

    task automatic set_flags(input logic [3:0] nzcv);
        u_if1.flag_we = 1'b1;
        {u_if1.negative_flag, u_if1.zd_flag, u_if1.carry_flag, u_if1.overflow_flag} = nzcv;
    endtask

    // Advance one edge, then pop and compare every queued expectation.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".sr"},  u_if1.sr_rdata,              e.sr);
            chk({e.tag, ".sv"},  {3'b0, u_if1.shadow_valid},  {3'b0, e.sv});
            chk({e.tag, ".tv"},  {3'b0, u_if1.take_valid},    {3'b0, e.tv});
            chk({e.tag, ".tb"},  {3'b0, u_if1.take_branch},   {3'b0, e.tb});
            chk({e.tag, ".sr0"}, u_if0.sr_rdata,              e.sr);
            chk({e.tag, ".tv0"}, {3'b0, u_if0.take_valid},    {3'b0, e.tv});
            chk({e.tag, ".tb0"}, {3'b0, u_if0.take_branch},   {3'b0, e.tb0});
        end
    endtask

    initial begin
        logic [3:0] prev_sr;
        logic       e1, e0;

        idle();
        rst = 1'b1; u_if1.cond_valid = 1'b1; u_if1.cond_code = 4'hE;
        push("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        idle(); set_flags(4'b0100);
        push("flag_z", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        idle(); rst = 1'b1;
        push("reset2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Same-cycle flags + LT: bypass sees N=1,V=0, registered path sees 0000.
        idle(); set_flags(4'b1000); u_if1.cond_valid = 1'b1; u_if1.cond_code = 4'hB;
        push("lt_fwd", 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();

        idle(); set_flags(4'b0100); u_if1.sr_we = 1'b1; u_if1.sr_wdata = 4'b1010;
        push("srwe_prio", 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();

        idle(); set_flags(4'b0100); u_if1.int_save = 1'b1;
        push("save", 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc();

        idle(); u_if1.int_restore = 1'b1; u_if1.sr_we = 1'b1; u_if1.sr_wdata = 4'b0001;
        push("restore", 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();

        idle(); u_if1.int_restore = 1'b1; set_flags(4'b0010);
        push("restore_nov", 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();

        idle(); u_if1.stall = 1'b1; set_flags(4'b0100); u_if1.sr_we = 1'b1;
        u_if1.sr_wdata = 4'b1111; u_if1.int_save = 1'b1;
        u_if1.cond_valid = 1'b1; u_if1.cond_code = 4'hF;
        push("stall", 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();

        idle(); u_if1.cond_valid = 1'b1; u_if1.cond_code = 4'hE;
        push("al", 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc();

        idle(); u_if1.cond_valid = 1'b1; u_if1.cond_code = 4'hF;
        push("nv_b2b", 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();

        // Sweep every code over every status value written the same cycle.
        prev_sr = 4'b0010;
        for (int v = 0; v < 16; v++) begin
            for (int c = 0; c < 16; c++) begin
                idle();
                u_if1.sr_we = 1'b1; u_if1.sr_wdata = 4'(v);
                u_if1.cond_valid = 1'b1; u_if1.cond_code = 4'(c);
                e1 = ref_cond(4'(v), 4'(c));
                e0 = ref_cond(prev_sr, 4'(c));
                push($sformatf("sweep_%0h_%0h", v, c), 4'(v), 1'b0, 1'b1, e1, e0);
                cyc();
                prev_sr = 4'(v);
            end
        end

        idle(); rst = 1'b1; u_if1.cond_valid = 1'b1; u_if1.cond_code = 4'hE;
        u_if1.sr_we = 1'b1; u_if1.sr_wdata = 4'b1111;
        push("rst_req", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        idle();
        push("idle_after", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
